reg_reader: RTL
===============

Name: reg_reader

Overview:
Sequencing FSM that sits directly downstream of reg_writer and the regfile. It walks the regfile read port across a contiguous register range in either direction. Each read word is streamed out through a valid/ready handshake backed by a one-entry output holding register. Typical use: dump the block that reg_writer just filled, for checking or for transfer to the next consumer.

Parameters:
BASE_REG, 1, lowest register number of the range (0-31)
NUM_REGS, 6, number of registers read per run (1-32); all addresses are computed modulo 32

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
go  input  1  start request; sampled only in IDLE
direction  input  1  0 = ascending, 1 = descending; latched together with an accepted go
rd_regnum  output  5  regfile read-port register number
rd_data  input  32  regfile read data; combinational from rd_regnum, same cycle
out_data  output  32  streamed register value
out_regnum  output  5  register number that out_data came from
out_valid  output  1  out_data/out_regnum are valid
out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a run completes

Behaviour:
- Reset (reset==0 at a rising edge), regardless of state:
  - state=IDLE, idx=0, dir=0
  - out_valid=0, out_data=0, out_regnum=0, done=0
  - an in-flight run is aborted and any held word is discarded
- Register numbering:
  - start = BASE_REG when dir=0; start = (BASE_REG+NUM_REGS-1) mod 32 when dir=1
  - rd_regnum = (start + idx) mod 32 when dir=0; (start - idx) mod 32 when dir=1
  - in IDLE, rd_regnum = BASE_REG
- States: IDLE, RUN, DRAIN. busy = (state != IDLE).
- IDLE:
  - go=1: dir<=direction, idx<=0, move to RUN.
  - go=0: remain in IDLE.
- RUN:
  - load = !out_valid || out_ready.
  - When load=1:
    - out_data<=rd_data, out_regnum<=rd_regnum, out_valid<=1, idx<=idx+1
    - if idx==NUM_REGS-1, move to DRAIN.
  - When load=0: out_data, out_regnum and idx hold. The word stays stable until it is accepted.
- DRAIN:
  - out_valid && out_ready: out_valid<=0, done<=1 for exactly one cycle, move to IDLE.
  - otherwise: hold.
- done is high only in the cycle after the final handshake and is cleared on the next edge.
- Timing (go accepted at edge E0, out_ready held high):
  - word k is captured at edge E(k+1) and is valid during the following cycle
  - the last word is consumed at E(NUM_REGS+1)
  - done is high in the cycle after that
  - throughput is 1 word per cycle
- go and direction are ignored while busy. A new run can start on the edge after done.
- Register 0 is not special: whatever the regfile returns (0) is streamed.
- NUM_REGS=1: one word, then DRAIN.
- idx is 6 bits so that NUM_REGS=32 is supported.

Test Plan:
1. Preload r1..r6 = 32'hd01..d06, out_ready=1, go=1/direction=0 for one cycle -> out_valid high for 6 consecutive cycles with out_data d01,d02,..,d06 and out_regnum 1..6; done is a single 1-cycle pulse after the last word; busy then drops to 0.
2. Same preload, direction=1 -> out_data d06..d01, out_regnum 6..1, then a single done pulse.
3. Ascending run, out_ready=0 for 3 cycles while out_data=32'hd02 -> out_data/out_regnum hold d02/2 and out_valid stays 1; on release the sequence continues d03..d06 with no word lost or duplicated.
4. go=1 with direction toggled mid-run -> ignored; the sequence and the done timing are identical to scenario 1.
5. reset=0 for one edge after 3 words -> next cycle out_valid=0, busy=0, done=0; a subsequent go restarts from r1 (d01).
6. BASE_REG=30, NUM_REGS=4, direction=0, r30=32'hA, r31=32'hB, r1=32'hC -> out_regnum 30,31,0,1 and out_data A, B, 0, C.

Source files
------------

// File: rtl/reg_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_reader
// Brief    : Walks the regfile read port over a contiguous register range
//            (ascending or descending, modulo 32) and streams each word out
//            through a valid/ready handshake with a one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_reader #(
  parameter int BASE_REG = 1,
  parameter int NUM_REGS = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        direction,
  output logic [4:0]  rd_regnum,
  input  logic [31:0] rd_data,
  output logic [31:0] out_data,
  output logic [4:0]  out_regnum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  // First register of a run for each direction; 5-bit arithmetic wraps mod 32.
  localparam logic [4:0] c_START_ASC = 5'(BASE_REG % 32);
  localparam logic [4:0] c_START_DSC = 5'((BASE_REG + NUM_REGS - 1) % 32);
  // idx is 6 bits wide so that a full 32-register run has a representable last index.
  localparam logic [5:0] c_LAST_IDX  = 6'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [5:0]  idx_q;
  logic [5:0]  idx_d;
  logic        dir_q;
  logic [31:0] out_data_q;
  logic [4:0]  out_regnum_q;
  logic        out_valid_q;
  logic        done_q;
  logic        load;

  // Read address, next index and holding-register load enable.
  always_comb begin
    idx_d = idx_q + 6'd1;
    load  = !out_valid_q || out_ready;
    if (state_q == IDLE) begin
      rd_regnum = c_START_ASC;
    end else if (dir_q) begin
      rd_regnum = c_START_DSC - idx_q[4:0];
    end else begin
      rd_regnum = c_START_ASC + idx_q[4:0];
    end
  end

  // Sequencer: start on go, capture one word per free slot, drain the last word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 6'd0;
      dir_q        <= 1'b0;
      out_data_q   <= 32'd0;
      out_regnum_q <= 5'd0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            dir_q   <= direction;
            idx_q   <= 6'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A held word that is being accepted this edge is replaced in place.
          if (load) begin
            out_data_q   <= rd_data;
            out_regnum_q <= rd_regnum;
            out_valid_q  <= 1'b1;
            idx_q        <= idx_d;
            if (idx_q == c_LAST_IDX) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_regnum = out_regnum_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
